// File: rtl/shift_seq_ctrl.sv
// Serial shift-chain sequencer: captures a parallel word on start, shifts it MSB-first
// into a WIDTH-bit chain (mirrored on q) and pulses done when the chain holds the word.
module shift_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             shift_en,
  output logic             ser_data,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] hold_shifted;
  logic [CNT_W-1:0] bit_idx;

  // Bit selection goes through a shift so the index width need not match $clog2(WIDTH).
  always_comb begin
    shift_en     = (state == ST_SHIFT);
    bit_idx      = LAST_IDX - count;
    hold_shifted = hold >> bit_idx;
    ser_data     = shift_en & hold_shifted[0];
  end

  // NOTE: every register below uses <= so all updates see the pre-edge values;
  // the q shift relies on ser_data computed from the old count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      hold  <= '0;
      q     <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            hold  <= din;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          q     <= {q[WIDTH-2:0], ser_data};
          count <= count + CNT_W'(1);
          if (count == LAST_IDX) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          count <= '0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios plus random traffic on a
// WIDTH=5 instance against a transaction-level model, and a directed WIDTH=8 run.
module tb_shift_seq_ctrl;

  localparam int W = 5;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic         start, busy, done, shift_en, ser_data;
  logic [W-1:0] din, q;
  logic [2:0]   count;

  logic         start8, busy8, done8, shift_en8, ser_data8;
  logic [7:0]   din8, q8;
  logic [3:0]   count8;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .start(start), .din(din), .busy(busy), .done(done),
    .shift_en(shift_en), .ser_data(ser_data), .q(q), .count(count)
  );

  shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .clr(clr), .start(start8), .din(din8), .busy(busy8), .done(done8),
    .shift_en(shift_en8), .ser_data(ser_data8), .q(q8), .count(count8)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Transaction model: k = edges since the accepting edge of the live transaction.
  bit m_act   = 1'b0;
  int m_k     = 0;
  int m_word  = 0;
  int m_qbase = 0;
  int m_q     = 0;

  int cyc      = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int ser_log  = 0;
  int done_at[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int  e_q;
    bit  shifting;
    shifting = m_act && (m_k < W);
    e_q = m_act ? (((m_qbase << m_k) | (m_word >> (W - m_k))) & ((1 << W) - 1)) : m_q;
    check("busy", 32'(busy), 32'(m_act));
    check("done", 32'(done), 32'(m_act && (m_k == W)));
    check("shift_en", 32'(shift_en), 32'(shifting));
    check("ser_data", 32'(ser_data), shifting ? 32'((m_word >> (W - 1 - m_k)) & 1) : 32'd0);
    check("count", 32'(count), m_act ? 32'(m_k) : 32'd0);
    check("q", 32'(q), 32'(e_q));
  endtask

  task automatic step(input logic s, input logic [W-1:0] d);
    start = s;
    din   = d;
    @(posedge clk);
    if (!m_act) begin
      if (s) begin
        m_act   = 1'b1;
        m_k     = 0;
        m_word  = int'(d);
        m_qbase = m_q;
      end
    end else begin
      m_k++;
      if (m_k == W) m_q = m_word;
      if (m_k > W) m_act = 1'b0;
    end
    #1;
    cyc++;
    check_model();
    if (done) begin
      done_cnt++;
      done_at.push_back(cyc);
    end
    if (busy) busy_cyc++;
    if (shift_en) ser_log = (ser_log << 1) | int'(ser_data);
  endtask

  // Asynchronous clear between edges; outputs must clear before any clock edge.
  task automatic async_clr();
    #1;
    clr = 1'b1;
    #1;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_q", 32'(q), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_shift_en", 32'(shift_en), 32'd0);
    check("clr_q8", 32'(q8), 32'd0);
    clr    = 1'b0;
    m_act  = 1'b0;
    m_k    = 0;
    m_q    = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ser8;
    int d8cnt;
    clr    = 1'b1;
    start  = 1'b0;
    din    = '0;
    start8 = 1'b0;
    din8   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ser_data", 32'(ser_data), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    clr = 1'b0;
    repeat (2) step(1'b0, 5'b11111);

    // Basic transaction 10110
    done_cnt = 0; busy_cyc = 0; ser_log = 0;
    step(1'b1, 5'b10110);
    repeat (6) step(1'b0, 5'b00000);
    check("t2_ser_seq", 32'(ser_log), 32'b10110);
    check("t2_q", 32'(q), 32'b10110);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_busy_cycles", 32'(busy_cyc), 32'd6);

    // start while shifting is ignored
    done_cnt = 0;
    step(1'b1, 5'b10110);
    step(1'b0, 5'b00000);
    step(1'b1, 5'b01111);
    repeat (5) step(1'b0, 5'b01111);
    check("t3_q", 32'(q), 32'b10110);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Abort mid-transaction with clear
    done_cnt = 0;
    step(1'b1, 5'b11111);
    repeat (3) step(1'b0, 5'b00000);
    async_clr();
    check("t4_no_done", 32'(done_cnt), 32'd0);
    step(1'b1, 5'b00001);
    repeat (6) step(1'b0, 5'b00000);
    check("t4_q", 32'(q), 32'b00001);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Back-to-back with start held high
    done_cnt = 0;
    done_at.delete();
    step(1'b1, 5'b10101);
    repeat (7) step(1'b1, 5'b01010);
    repeat (6) step(1'b0, 5'b00000);
    check("t5_done_cnt", 32'(done_cnt), 32'd2);
    if (done_at.size() == 2)
      check("t5_done_gap", 32'(done_at[1] - done_at[0]), 32'd7);
    check("t5_q", 32'(q), 32'b01010);

    // Random traffic with occasional async clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) async_clr();
      else step($urandom_range(0, 2) == 0, W'($urandom));
    end
    repeat (7) step(1'b0, 5'b00000);

    // WIDTH=8 instance, din=A5
    start  = 1'b0;
    ser8   = 0;
    d8cnt  = 0;
    start8 = 1'b1;
    din8   = 8'hA5;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    din8   = 8'h00;
    for (int i = 0; i < 11; i++) begin
      if (shift_en8) ser8 = (ser8 << 1) | int'(ser_data8);
      if (done8) begin
        d8cnt++;
        check("t6_q8_at_done", 32'(q8), 32'hA5);
        check("t6_count8_at_done", 32'(count8), 32'd8);
      end
      @(posedge clk);
      #1;
    end
    check("t6_ser_seq", 32'(ser8), 32'hA5);
    check("t6_done_pulses", 32'(d8cnt), 32'd1);
    check("t6_busy8_idle", 32'(busy8), 32'd0);
    check("t6_count8_idle", 32'(count8), 32'd0);
    check("t6_q8_final", 32'(q8), 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
